shift_left_pipe: RTL and testbench



---
 rtl/shift_left_pipe.sv | 109 ++++++++++
 tb/tb_shift_left_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_pipe.sv
// rtl/shift_left_pipe.sv - two-stage elastic symbol-granular left shifter with fill insertion
module shift_left_pipe #(
    parameter int SYM_W = 5,
    parameter int NSYM  = 10,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYM_W*NSYM-1:0]   in_data,
    input  logic [2:0]              shift,
    input  logic [SYM_W-1:0]        fill,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYM_W*NSYM-1:0]   out_data,
    output logic                    out_err,
    output logic [CNT_W-1:0]        err_count
);

    localparam int DW = SYM_W * NSYM;

    // Stage 1 holding registers
    logic               s1_valid;
    logic [DW-1:0]      s1_data;
    logic               s1_shift2;
    logic [SYM_W-1:0]   s1_fill;
    logic               s1_illegal;

    // Combinational shift network and flow control
    logic [DW-1:0]      sh1_word;
    logic [DW-1:0]      sh2_word;
    logic [DW-1:0]      s2_word;
    logic               in_illegal;
    logic               s2_load;
    logic               s1_load;

    assign in_illegal = shift[2] & (shift[1] | shift[0]);
    assign s2_load    = !out_valid || out_ready;
    assign s1_load    = !s1_valid || s2_load;
    assign in_ready   = s1_load;

    // Stage 1 datapath: 1-symbol then 2-symbol shift of the incoming word
    always_comb begin
        sh1_word = in_data;
        if (shift[0]) begin
            sh1_word = {in_data[DW-SYM_W-1:0], fill};
        end
        sh2_word = sh1_word;
        if (shift[1]) begin
            sh2_word = {sh1_word[DW-2*SYM_W-1:0], fill, fill};
        end
    end

    // Stage 2 datapath: 4-symbol shift, or the all-fill word for an illegal amount
    always_comb begin
        s2_word = s1_data;
        if (s1_shift2) begin
            s2_word = {s1_data[DW-4*SYM_W-1:0], {4{s1_fill}}};
        end
        if (s1_illegal) begin
            s2_word = {NSYM{s1_fill}};
        end
    end

    // Stage 1 register: loads whenever it is empty or its contents move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_shift2  <= 1'b0;
            s1_fill    <= '0;
            s1_illegal <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data    <= sh2_word;
                s1_shift2  <= shift[2];
                s1_fill    <= fill;
                s1_illegal <= in_illegal;
            end
        end
    end

    // Stage 2 register: output beat, held stable while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_word;
                out_err  <= s1_illegal;
            end
        end
    end

    // Saturating count of illegal-shift beats accepted at the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (in_valid && s1_load && in_illegal && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_left_pipe.sv
// tb/tb_shift_left_pipe.sv - self-checking bench for shift_left_pipe
module tb_shift_left_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [2:0]  shift;
    logic [4:0]  fill;
    logic        out_valid;
    logic        out_ready;
    logic [49:0] out_data;
    logic        out_err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    // model state
    logic [49:0] exp_data_q[$];
    logic        exp_err_q[$];
    int          model_err = 0;
    int          n_out = 0;
    bit          prev_stall = 0;
    logic [49:0] prev_data;
    logic        prev_err;

    localparam logic [49:0] W0 = {5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0};

    shift_left_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift(shift), .fill(fill),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: output symbol i is input symbol i-k, fill below k, all fill when k>4
    function automatic logic [49:0] model(input logic [49:0] d, input int k, input logic [4:0] f);
        logic [49:0] r;
        for (int i = 0; i < 10; i++) begin
            if (k > 4 || i < k) r[5*i +: 5] = f;
            else                r[5*i +: 5] = d[5*(i-k) +: 5];
        end
        return r;
    endfunction

    // Compare process: handshakes are stable at the falling edge and take effect on the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_data_q.delete();
            exp_err_q.delete();
            model_err  = 0;
            prev_stall = 0;
        end else begin
            check("err_count", {56'd0, err_count}, 64'(model_err));
            if (prev_stall) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_data", {14'd0, out_data}, {14'd0, prev_data});
                check("stall_err", {63'd0, out_err}, {63'd0, prev_err});
            end
            if (in_valid && in_ready) begin
                exp_data_q.push_back(model(in_data, int'(shift), fill));
                exp_err_q.push_back(shift > 3'd4);
                if (shift > 3'd4 && model_err < 255) model_err++;
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("out_data", {14'd0, out_data}, {14'd0, exp_data_q.pop_front()});
                    check("out_err", {63'd0, out_err}, {63'd0, exp_err_q.pop_front()});
                end
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send_beat(input logic [49:0] d, input logic [2:0] k, input logic [4:0] f);
        int  t = 0;
        bit  acc = 0;
        in_data  = d;
        shift    = k;
        fill     = f;
        in_valid = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_data_q.size() != 0 || out_valid) && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drained", 64'(exp_data_q.size()), 64'd0);
    endtask

    logic [49:0] lit[4];
    logic [2:0]  sw[4];
    int          n_out0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0; fill = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {14'd0, out_data}, 64'd0);
        check("rst_out_err", {63'd0, out_err}, 64'd0);
        check("rst_err_count", {56'd0, err_count}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // model pinned against hand-computed words
        check("model_pin_k2", {14'd0, model(W0, 2, 5'd31)},
              {14'd0, 5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd31,5'd31});
        check("model_pin_ill", {14'd0, model(W0, 6, 5'd10)}, {14'd0, {10{5'd10}}});

        // 1: legal shift and latency
        @(posedge clk); #1;
        send_beat(W0, 3'd2, 5'd31);
        check("t1_not_yet", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_data", {14'd0, out_data}, {14'd0, 5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd31,5'd31});
        check("t1_err", {63'd0, out_err}, 64'd0);
        drain();

        // 2: back-to-back sweep
        sw[0] = 3'd0; sw[1] = 3'd1; sw[2] = 3'd3; sw[3] = 3'd4;
        lit[0] = W0;
        lit[1] = {5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd17};
        lit[2] = {5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd17,5'd17,5'd17};
        lit[3] = {5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd17,5'd17,5'd17,5'd17};
        for (int j = 0; j < 4; j++) begin
            send_beat(W0, sw[j], 5'd17);
            if (j >= 1) begin
                check("t2_valid", {63'd0, out_valid}, 64'd1);
                check("t2_data", {14'd0, out_data}, {14'd0, lit[j-1]});
            end
        end
        @(posedge clk); #1;
        check("t2_valid_last", {63'd0, out_valid}, 64'd1);
        check("t2_data_last", {14'd0, out_data}, {14'd0, lit[3]});
        drain();

        // 3: illegal shifts and saturation
        send_beat(W0, 3'd5, 5'd10);
        check("t3_cnt1", {56'd0, err_count}, 64'd1);
        send_beat(W0, 3'd7, 5'd10);
        check("t3_cnt2", {56'd0, err_count}, 64'd2);
        check("t3_data", {14'd0, out_data}, {14'd0, {10{5'd10}}});
        check("t3_err", {63'd0, out_err}, 64'd1);
        for (int j = 0; j < 300; j++) send_beat(W0 ^ 50'(j), 3'(5 + (j % 3)), 5'd10);
        drain();
        check("t3_saturated", {56'd0, err_count}, 64'd255);

        // 4: backpressure with random legal shifts
        n_out0 = n_out;
        fork
            begin
                for (int j = 0; j < 6; j++)
                    send_beat({$urandom, $urandom}, 3'($urandom_range(0, 4)), 5'($urandom_range(0, 31)));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
                check("t4_out_valid_held", {63'd0, out_valid}, 64'd1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("t4_beats_out", 64'(n_out - n_out0), 64'd6);

        // 5: reset mid-stream, plus bubble collapse
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_beat(W0, 3'd6, 5'd2);
        drain();
        out_ready = 1'b0;
        send_beat(W0, 3'd5, 5'd2);
        @(posedge clk); #1;
        check("t5_bubble_ready", {63'd0, in_ready}, 64'd1);
        send_beat(W0, 3'd7, 5'd2);
        check("t5_full_ready", {63'd0, in_ready}, 64'd0);
        check("t5_cnt3", {56'd0, err_count}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t5_rst_data", {14'd0, out_data}, 64'd0);
        check("t5_rst_cnt", {56'd0, err_count}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send_beat(W0, 3'd1, 5'd3);
        check("t5_not_yet", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("t5_valid", {63'd0, out_valid}, 64'd1);
        check("t5_data", {14'd0, out_data}, {14'd0, 5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'd3});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
